// File: rtl/data_mem_hs.sv
// Handshaked single-port data RAM for the jacaranda-8 load/store path,
// with a hardware clear engine that zeroes the array after reset and on demand.
module data_mem_hs #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              clear_req,
    output logic              busy,
    output logic              dbg_state
);

    // Handshake: a request is taken on any rising edge where req_valid && req_ready;
    // req_we/addr/wdata only matter in that cycle. Reads answer with a one-cycle
    // rsp_valid pulse on the next cycle and there is no response backpressure.

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // ready_q is high exactly in IDLE, so accept never fires during a sweep.
    assign accept = req_valid && ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        mem_we      = 1'b0;
        mem_waddr   = req_addr;
        mem_wdata   = req_wdata;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_we) begin
                        mem_we = 1'b1;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = mem[req_addr];
                    end
                end
                // A request taken alongside clear_req still completes normally.
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET_STATE;
            cnt_q       <= '0;
            ready_q     <= !CLEAR_ON_RESET;
            busy_q      <= CLEAR_ON_RESET;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Storage has no reset so it can map onto a RAM macro.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs: default instance plus a 16-bit/16-word
// instance that comes up idle.
module tb_data_mem_hs;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;

    logic       req_valid, req_ready, req_we, rsp_valid, clear_req, busy, dbg_state;
    logic [7:0] req_addr, req_wdata, rsp_rdata;

    logic        req_valid_b, req_ready_b, req_we_b, rsp_valid_b, clear_req_b, busy_b, dbg_state_b;
    logic [3:0]  req_addr_b;
    logic [15:0] req_wdata_b, rsp_rdata_b;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    data_mem_hs dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .clear_req (clear_req),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    data_mem_hs #(.DATA_W(16), .ADDR_W(4), .CLEAR_ON_RESET(1'b0)) dut_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid_b),
        .req_ready (req_ready_b),
        .req_we    (req_we_b),
        .req_addr  (req_addr_b),
        .req_wdata (req_wdata_b),
        .rsp_valid (rsp_valid_b),
        .rsp_rdata (rsp_rdata_b),
        .clear_req (clear_req_b),
        .busy      (busy_b),
        .dbg_state (dbg_state_b)
    );

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle;
        req_valid   = 1'b0; req_we   = 1'b0; req_addr   = '0; req_wdata   = '0; clear_req   = 1'b0;
        req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; clear_req_b = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        drive_idle();
        repeat (3) tick();
        total++; if (busy !== 1'b1)        begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        total++; if (req_ready !== 1'b0)   begin bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        total++; if (rsp_valid !== 1'b0)   begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_rdata !== 8'h00)  begin bad++; $display("FAIL reset_rsp_rdata: got %h want 00", rsp_rdata); end
        total++; if (busy_b !== 1'b0)      begin bad++; $display("FAIL reset_b_busy: got %b want 0", busy_b); end
        total++; if (req_ready_b !== 1'b1) begin bad++; $display("FAIL reset_b_ready: got %b want 1", req_ready_b); end
        total++; if (rsp_valid_b !== 1'b0) begin bad++; $display("FAIL reset_b_rsp_valid: got %b want 0", rsp_valid_b); end
    endtask

    task automatic test_post_reset_clear;
        int n;
        int ready_hi;
        logic [7:0] addrs [3];
        addrs = '{8'h00, 8'h7F, 8'hFF};
        reset_n = 1'b1;
        n = 0;
        ready_hi = 0;
        while (busy === 1'b1 && n < 400) begin
            if (req_ready !== 1'b0) ready_hi++;
            tick();
            n++;
        end
        total++; if (n != 256)            begin bad++; $display("FAIL post_reset_busy_cycles: got %0d want 256", n); end
        total++; if (ready_hi != 0)       begin bad++; $display("FAIL post_reset_ready_during_busy: got %0d want 0", ready_hi); end
        total++; if (req_ready !== 1'b1)  begin bad++; $display("FAIL post_reset_ready_after: got %b want 1", req_ready); end
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = addrs[i];
            tick();
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL post_reset_rd_valid[%0h]: got %b want 1", addrs[i], rsp_valid); end
            total++; if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL post_reset_rd_data[%0h]: got %h want 00", addrs[i], rsp_rdata); end
            req_valid = 1'b0;
            tick();
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL post_reset_rd_pulse[%0h]: got %b want 0", addrs[i], rsp_valid); end
        end
    endtask

    task automatic test_write_read;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'hA5;
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_no_response: got %b want 0", rsp_valid); end
        req_we = 1'b0;
        tick();
        total++; if (rsp_valid !== 1'b1)  begin bad++; $display("FAIL wr_rd_valid: got %b want 1", rsp_valid); end
        total++; if (rsp_rdata !== 8'hA5) begin bad++; $display("FAIL wr_rd_data: got %h want a5", rsp_rdata); end
        req_valid = 1'b0;
        tick();
        total++; if (rsp_valid !== 1'b0)  begin bad++; $display("FAIL wr_rd_pulse: got %b want 0", rsp_valid); end
        total++; if (rsp_rdata !== 8'hA5) begin bad++; $display("FAIL wr_rd_hold: got %h want a5", rsp_rdata); end
    endtask

    task automatic test_streaming;
        int ready_drop;
        logic [7:0] exp;
        ready_drop = 0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 8'(i); req_wdata = 8'(i) ^ 8'h3C;
            if (req_ready !== 1'b1) ready_drop++;
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            req_we = 1'b0; req_addr = 8'(i);
            exp_q.push_back(8'(i) ^ 8'h3C);
            if (req_ready !== 1'b1) ready_drop++;
            tick();
            exp = exp_q.pop_front();
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, rsp_valid); end
            total++; if (rsp_rdata !== exp)  begin bad++; $display("FAIL stream_data[%0d]: got %h want %h", i, rsp_rdata, exp); end
        end
        req_valid = 1'b0;
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL stream_end_valid: got %b want 0", rsp_valid); end
        total++; if (ready_drop != 0)    begin bad++; $display("FAIL stream_ready_drop: got %0d want 0", ready_drop); end
        total++; if (exp_q.size() != 0)  begin bad++; $display("FAIL stream_queue_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_clear_collision;
        int cycles;
        int k;
        int leaked;
        logic [7:0] addrs [3];
        addrs = '{8'h20, 8'hF0, 8'h30};
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'h55;
        tick();
        req_we = 1'b0; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        total++; if (rsp_valid !== 1'b1)  begin bad++; $display("FAIL coll_rd_valid: got %b want 1", rsp_valid); end
        total++; if (rsp_rdata !== 8'h55) begin bad++; $display("FAIL coll_rd_data: got %h want 55", rsp_rdata); end
        total++; if (busy !== 1'b1)       begin bad++; $display("FAIL coll_busy_rise: got %b want 1", busy); end
        total++; if (req_ready !== 1'b0)  begin bad++; $display("FAIL coll_ready_fall: got %b want 0", req_ready); end
        cycles = 1; k = 0; leaked = 0;
        while (busy === 1'b1 && k < 400) begin
            req_valid = 1'b1; req_we = k[0]; req_addr = k[0] ? 8'hF0 : 8'h30; req_wdata = 8'hFF;
            tick();
            k++;
            if (busy === 1'b1) begin
                cycles++;
                if (rsp_valid !== 1'b0) leaked++;
            end
        end
        req_valid = 1'b0;
        total++; if (cycles != 256) begin bad++; $display("FAIL coll_busy_cycles: got %0d want 256", cycles); end
        total++; if (leaked != 0)   begin bad++; $display("FAIL coll_read_accepted: got %0d want 0", leaked); end
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = addrs[i];
            tick();
            total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00) begin
                bad++; $display("FAIL coll_after[%0h]: got v=%b d=%h want v=1 d=00", addrs[i], rsp_valid, rsp_rdata);
            end
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_sweep;
        int n;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h05; req_wdata = 8'h66;
        tick();
        req_addr = 8'hC8; req_wdata = 8'h77;
        tick();
        req_valid = 1'b0; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (100) tick();
        reset_n = 1'b0;
        #1;
        total++; if (busy !== 1'b1)      begin bad++; $display("FAIL mid_reset_busy: got %b want 1", busy); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready: got %b want 0", req_ready); end
        repeat (2) tick();
        reset_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        total++; if (n != 256) begin bad++; $display("FAIL mid_restart_cycles: got %0d want 256", n); end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hC8;
        tick();
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00) begin
            bad++; $display("FAIL mid_restart_c8: got v=%b d=%h want v=1 d=00", rsp_valid, rsp_rdata);
        end
        req_we = 1'b1; req_addr = 8'h05; req_wdata = 8'h5A;
        tick();
        req_we = 1'b0;
        tick();
        req_valid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h5A) begin
            bad++; $display("FAIL pend_read: got v=%b d=%h want v=1 d=5a", rsp_valid, rsp_rdata);
        end
        reset_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0)  begin bad++; $display("FAIL pend_reset_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL pend_reset_data: got %h want 00", rsp_rdata); end
        repeat (2) tick();
        reset_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        total++; if (n != 256) begin bad++; $display("FAIL pend_restart_cycles: got %0d want 256", n); end
    endtask

    task automatic test_variant;
        int n;
        int guard;
        total++; if (req_ready_b !== 1'b1) begin bad++; $display("FAIL var_ready: got %b want 1", req_ready_b); end
        req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 4'hF; req_wdata_b = 16'hBEEF;
        tick();
        req_we_b = 1'b0;
        tick();
        req_valid_b = 1'b0;
        total++; if (rsp_valid_b !== 1'b1)     begin bad++; $display("FAIL var_rd_valid: got %b want 1", rsp_valid_b); end
        total++; if (rsp_rdata_b !== 16'hBEEF) begin bad++; $display("FAIL var_rd_data: got %h want beef", rsp_rdata_b); end
        clear_req_b = 1'b1;
        tick();
        clear_req_b = 1'b0;
        total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL var_busy_rise: got %b want 1", busy_b); end
        n = 1; guard = 0;
        while (busy_b === 1'b1 && guard < 100) begin
            tick();
            guard++;
            if (busy_b === 1'b1) n++;
        end
        total++; if (n != 16)              begin bad++; $display("FAIL var_busy_cycles: got %0d want 16", n); end
        total++; if (req_ready_b !== 1'b1) begin bad++; $display("FAIL var_ready_after: got %b want 1", req_ready_b); end
        req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = 4'hF;
        tick();
        req_valid_b = 1'b0;
        total++; if (rsp_valid_b !== 1'b1 || rsp_rdata_b !== 16'h0000) begin
            bad++; $display("FAIL var_after_clear: got v=%b d=%h want v=1 d=0000", rsp_valid_b, rsp_rdata_b);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_post_reset_clear();
        test_write_read();
        test_streaming();
        test_clear_collision();
        test_reset_mid_sweep();
        test_variant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_hs.md
Name: data_mem_hs

Overview:
- Parametrised, handshaked successor to the CPU's flat 8-bit data memory.
- Single-port synchronous RAM of DEPTH words × DATA_W bits.
- Valid/ready request interface with a registered 1-cycle read response.
- Hardware clear engine zeroes the whole array after reset (optional) and on demand. Sits between the jacaranda-8 core's load/store path and its data RAM.

Parameters:
- DATA_W, 8, word width in bits (≥1).
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words (derived, not overridable).
- CLEAR_ON_RESET, 1, 1 = run a full clear sweep automatically after reset release; 0 = come up idle with contents undefined.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read; sampled with req_valid.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data valid; 1-cycle pulse.
- rsp_rdata  out  DATA_W  read data.
- clear_req  in  1  request a full-array clear; level, sampled per cycle.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (reset_n=0, async): state ← CLEAR if CLEAR_ON_RESET else IDLE; clear counter ← 0; rsp_valid=0; rsp_rdata=0. The array itself is not reset.
- During reset, outputs are:
  - CLEAR_ON_RESET=1: busy=1, req_ready=0.
  - CLEAR_ON_RESET=0: busy=0, req_ready=1.
- States: IDLE, CLEAR.
- IDLE:
  - req_ready=1, busy=0.
  - Accept occurs when req_valid && req_ready at a rising edge.
  - Write accept: mem[req_addr] ← req_wdata at that edge. No response; rsp_valid stays 0.
  - Read accept: at that edge rsp_rdata ← mem[req_addr] and rsp_valid ← 1 for exactly one cycle. Latency is 1 cycle.
  - rsp_rdata holds its last value until the next read accept; it is not cleared when rsp_valid drops.
  - There is no response backpressure; the consumer must take data while rsp_valid=1.
  - Back-to-back requests accepted every cycle. A read the cycle after a write to the same address returns the new data.
  - clear_req=1 in IDLE: the state → CLEAR at the next edge and the counter ← 0.
  - clear_req and an accepted request in the same cycle: the request completes normally (a read still gives rsp_valid next cycle), and CLEAR starts next cycle.
- CLEAR:
  - req_ready=0, busy=1. req_valid is ignored; nothing is accepted and no array side effects occur.
  - Each cycle: mem[counter] ← 0 and counter ← counter+1.
  - When counter = DEPTH-1 is written, state → IDLE. The counter wraps to 0 (width ADDR_W, natural wrap).
  - The sweep lasts exactly DEPTH cycles. busy=1 for those DEPTH cycles; req_ready rises on the following cycle.
  - clear_req asserted during CLEAR is ignored; no restart and no extension.
  - clear_req still high on return to IDLE starts a new sweep. Requester should pulse it.
- Reset asserted mid-sweep: sweep abandons immediately; the counter restarts from 0 after release (if CLEAR_ON_RESET). Partially cleared contents are acceptable.
- Reset asserted the cycle after a read accept: rsp_valid forced 0 asynchronously.
- Address range: every req_addr is valid (DEPTH = 2**ADDR_W); no out-of-range handling.
- req_we, req_addr and req_wdata are don't-care when req_valid=0.
- The array is a plain reg array with no reset on its storage, so it can map to a RAM macro.

Test Plan:
- Post-reset clear, defaults: release reset_n → busy=1 and req_ready=0 for exactly 256 cycles, then req_ready=1. Reads of addrs 0x00, 0x7F and 0xFF return 0x00 with rsp_valid one cycle after accept.
- Write/read-back: write 0xA5 @0x10, then read @0x10 the next cycle → rsp_valid pulses 1 cycle later with rsp_rdata=0xA5. rsp_rdata keeps 0xA5 after rsp_valid falls.
- Streaming: 8 back-to-back writes (addr i, data i^0x3C, i=0..7) then 8 back-to-back reads → req_ready stays 1 throughout; 8 consecutive rsp_valid cycles with data i^0x3C in order.
- On-demand clear with collision: fill 0x20=0x55. Read @0x20 with clear_req=1 in the same cycle → response 0x55. busy rises next cycle, and req_valid held high during the sweep is never accepted. Afterwards @0x20 reads 0x00.
- Reset mid-sweep: assert reset_n=0 at sweep cycle 100 → busy remains 1. After release the sweep runs a full 256 cycles from addr 0. A read pending response at reset shows rsp_valid=0 immediately.
- Parameter variant DATA_W=16, ADDR_W=4, CLEAR_ON_RESET=0: req_ready=1 immediately after reset. Write 0xBEEF @0xF, read → 0xBEEF. clear_req pulse → busy exactly 16 cycles, then @0xF reads 0x0000.
